pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction fetch unit for the RISC-V core. It holds the program counter and fetches instructions from instruction memory over a req/ack handshake. It presents each instruction to decode over a valid/ready handshake. When decode retires an instruction, it advances the PC by the step from the next-PC selector: 4 for sequential flow, or the sign-extended, left-shifted branch offset. It is the producer of the instruction word the next-PC selector decodes and the consumer of the step that selector produces.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- MAX_WAIT, 15, maximum cycles to wait for imem_ack in REQ; 0 disables the timeout.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- incremento  in  32  PC step from next-PC selector; sampled only in the retire cycle.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; equals the current PC.
- imem_ack  in  1  memory has returned data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word; valid only when imem_ack=1.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  32  fetched instruction word.
- instr_pc  out  32  address the instruction was fetched from.
- instr_ready  in  1  decode accepts and retires the instruction.
- fetch_err  out  1  sticky error: misaligned PC or memory timeout.

## Operation
- FSM states: START, REQ, HOLD, ERROR.
- START: entered on reset, and lasts one cycle.
  - If pc[1:0]≠0, go to ERROR.
  - Otherwise go to REQ.
- REQ:
  - Outputs: imem_req=1 and imem_addr=pc, both stable until ack.
  - Wait counter (width $clog2(MAX_WAIT+1)) increments each cycle without ack.
  - On imem_ack=1: register instr←imem_rdata and instr_pc←pc, clear the counter, go to HOLD.
  - If MAX_WAIT>0 and the counter reaches MAX_WAIT with no ack: go to ERROR.
- HOLD:
  - Outputs: instr_valid=1 and imem_req=0. instr and instr_pc are held stable.
  - On instr_ready=1 (retire): pc←pc+incremento, computed modulo 2^32 with carry discarded.
  - If the new pc[1:0]≠0, go to ERROR; otherwise go to REQ.
- ERROR:
  - Outputs: imem_req=0, instr_valid=0, fetch_err=1.
  - pc, instr and instr_pc frozen.
  - Exited only by reset.
- imem_ack outside REQ is ignored.
- instr_ready outside HOLD is ignored.
- incremento is added as a two's-complement value, so negative branch offsets move the PC backward.
- An incremento with bit1 set (halfword offset; compressed ISA not supported) results in ERROR after retire.

## Timing
- Reset values (immediate on rst_n=0, asynchronous): state=START, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_err=0, wait counter=0.
- First imem_req: rising edge 1 after rst_n deasserts (START→REQ), visible in cycle 2.
- Ack to valid: ack sampled at edge N; instr_valid=1 from edge N.
- Retire to next request: instr_ready sampled at edge M; imem_req=1 with new address from edge M.
- Throughput with zero-wait memory and ready tied high: one instruction per 2 cycles.
- Simultaneous imem_ack and timeout expiry in the same cycle: the ack wins, go to HOLD.
- rst_n asserted mid-REQ or mid-HOLD: outputs go to reset values immediately and the in-flight fetch is abandoned. A late imem_ack after reset is ignored unless the FSM is in REQ.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=0x100 -> imem_req=0, instr_valid=0, fetch_err=0, imem_addr=0x100; after release, imem_req=1 with addr 0x100 one edge later.
- Sequential flow: zero-wait memory, incremento=4, instr_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_pc matches each fetched instr.
- Backward branch: at pc=0x10 retire with incremento=0xFFFF_FFF0 -> next imem_addr=0x0. Separately, pc=0xFFFF_FFFC with incremento=4 -> wraps to 0x0.
- Back-pressure: instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc and instr_valid=1 stable, imem_req=0, pc unchanged; on ready, pc advances exactly once.
- Timeout: MAX_WAIT=15, imem_ack never asserted -> fetch_err=1 and imem_req=0 after 15 REQ cycles, stay in ERROR; an ack arriving in the same cycle as expiry goes to HOLD instead.
- Misalignment and mid-operation reset:
  - Retire with incremento=6 at pc=0 -> fetch_err=1, no further imem_req.
  - Pulse rst_n low mid-REQ -> recovers to the reset-value sequence.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Bundle between the fetch unit, instruction memory and decode.
//
// Handshakes:
//   imem_req/imem_ack : the fetch unit raises imem_req with imem_addr and holds
//     both stable until memory answers; imem_ack=1 in a cycle means imem_rdata
//     carries the word for imem_addr and the request completes on that edge.
//   instr_valid/instr_ready : instr and instr_pc are stable while instr_valid=1;
//     a transfer (retire) happens on any rising edge where both are 1, and
//     incremento is sampled on that same edge.
interface pc_fetch_if;
    logic [31:0] incremento;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        fetch_err;

    // Fetch unit side.
    modport master (
        input  incremento,
        input  imem_ack,
        input  imem_rdata,
        input  instr_ready,
        output imem_req,
        output imem_addr,
        output instr_valid,
        output instr,
        output instr_pc,
        output fetch_err
    );

    // Memory / decode / next-PC selector side.
    modport slave (
        output incremento,
        output imem_ack,
        output imem_rdata,
        output instr_ready,
        input  imem_req,
        input  imem_addr,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        input  fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time from
// instruction memory, hands it to decode and advances the PC by the step from
// the next-PC selector when decode retires it. Misaligned PCs and memory
// timeouts park the unit in a sticky error state until reset.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        START = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    // Counter is at least one bit wide so MAX_WAIT=0 (timeout disabled) still
    // elaborates; in that case it simply wraps and is never compared.
    localparam int CW          = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int WAIT_LAST_I = (MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0;
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LAST_I);

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   instr_q;
    logic [31:0]   instr_pc_q;
    logic          imem_req_q;
    logic          instr_valid_q;
    logic          fetch_err_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   next_pc;
    logic          wait_expired;

    // PC after retire: two's-complement add, carry out discarded so the PC
    // wraps modulo 2^32 and negative offsets move backward.
    assign next_pc = pc + bus.incremento;

    // The current REQ cycle is the MAX_WAIT-th one without an ack.
    assign wait_expired = (MAX_WAIT > 0) && (wait_cnt == WAIT_LAST);

    // Fetch FSM; all handshake outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= START;
            pc            <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                START: begin
                    if (pc[1:0] != 2'b00) begin
                        state       <= ERROR;
                        fetch_err_q <= 1'b1;
                    end else begin
                        state      <= REQ;
                        imem_req_q <= 1'b1;
                    end
                end

                REQ: begin
                    // An ack in the expiry cycle still completes the fetch.
                    if (bus.imem_ack) begin
                        instr_q       <= bus.imem_rdata;
                        instr_pc_q    <= pc;
                        wait_cnt      <= '0;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state         <= HOLD;
                    end else if (wait_expired) begin
                        wait_cnt    <= '0;
                        imem_req_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state       <= ERROR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.instr_ready) begin
                        pc            <= next_pc;
                        instr_valid_q <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err_q <= 1'b1;
                            state       <= ERROR;
                        end else begin
                            imem_req_q <= 1'b1;
                            state      <= REQ;
                        end
                    end
                end

                ERROR: begin
                    // Everything frozen; only reset leaves this state.
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b1;
                end

                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.fetch_err   = fetch_err_q;
    assign fsm_state       = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a memory/decode model driven from tasks, with a
// scoreboard of expected {instr_pc, instr} pushed when memory answers and
// popped when decode retires.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0000_0100;
    localparam int          MAX_WAIT = 15;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    pc_fetch_if bus();

    pc_fetch_unit #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory content model: a fixed scramble of the address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Hold reset, check reset values, release on a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.incremento  = $urandom;
        repeat (2) @(negedge clk);
        check_eq("rst_req",      32'(bus.imem_req),    32'd0);
        check_eq("rst_valid",    32'(bus.instr_valid), 32'd0);
        check_eq("rst_err",      32'(bus.fetch_err),   32'd0);
        check_eq("rst_addr",     bus.imem_addr,        RST_PC);
        check_eq("rst_instr",    bus.instr,            32'd0);
        check_eq("rst_instr_pc", bus.instr_pc,         32'd0);
        rst_n    = 1'b1;
        model_pc = RST_PC;
        @(negedge clk);
    endtask

    // One full fetch: called on the falling edge where imem_req is expected.
    // lat = REQ cycles without ack before the ack cycle; stall = HOLD cycles
    // with instr_ready low; inc = step sampled at retire.
    task automatic fetch_one(input int lat, input logic [31:0] inc, input int stall);
        logic [63:0] e;
        check_eq("req", 32'(bus.imem_req), 32'd1);
        check_eq("addr", bus.imem_addr, model_pc);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check_eq("req_wait", 32'(bus.imem_req), 32'd1);
            check_eq("addr_wait", bus.imem_addr, model_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr_of(model_pc);
        exp_q.push_back({model_pc, instr_of(model_pc)});
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        check_eq("valid", 32'(bus.instr_valid), 32'd1);
        check_eq("req_hold", 32'(bus.imem_req), 32'd0);
        for (int i = 0; i < stall; i++) begin
            // A stray ack during HOLD must be ignored.
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = $urandom;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            check_eq("stall_valid",    32'(bus.instr_valid), 32'd1);
            check_eq("stall_req",      32'(bus.imem_req),    32'd0);
            check_eq("stall_instr",    bus.instr,            exp_q[0][31:0]);
            check_eq("stall_instr_pc", bus.instr_pc,         exp_q[0][63:32]);
            check_eq("stall_pc",       bus.imem_addr,        model_pc);
        end
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_eq("instr",    bus.instr,    e[31:0]);
            check_eq("instr_pc", bus.instr_pc, e[63:32]);
        end
        bus.instr_ready = 1'b1;
        bus.incremento  = inc;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.incremento  = $urandom;
        model_pc        = model_pc + inc;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    logic [31:0] incs [6];

    initial begin
        incs = '{32'd4, 32'd8, 32'hFFFF_FFF8, 32'h40, 32'd4, 32'hFFFF_FFFC};

        // Reset to 0x100, then branch back to 0x0.
        apply_reset();
        fetch_one(0, 32'hFFFF_FF00, 0);

        // Sequential zero-wait flow 0x0, 0x4, 0x8, 0xC.
        for (int i = 0; i < 4; i++) fetch_one(0, 32'd4, 0);

        // Backward branch at 0x10 -> 0x0.
        check_eq("pc_before_branch", model_pc, 32'h10);
        fetch_one(1, 32'hFFFF_FFF0, 0);

        // Jump to 0xFFFF_FFFC with back-pressure, then wrap to 0x0.
        fetch_one(2, 32'hFFFF_FFFC, 5);
        check_eq("pc_top", model_pc, 32'hFFFF_FFFC);
        fetch_one(0, 32'd4, 0);

        // Random latencies, stalls and aligned steps.
        for (int i = 0; i < 8; i++)
            fetch_one($urandom_range(0, 6), incs[$urandom_range(0, 5)], $urandom_range(0, 3));

        // Ack in the very cycle the timeout would expire: fetch completes.
        fetch_one(MAX_WAIT - 1, 32'd4, 0);

        // No ack at all: error after MAX_WAIT REQ cycles.
        check_eq("to_req", 32'(bus.imem_req), 32'd1);
        for (int i = 0; i < MAX_WAIT - 1; i++) @(negedge clk);
        check_eq("to_last_req", 32'(bus.imem_req), 32'd1);
        check_eq("to_last_err", 32'(bus.fetch_err), 32'd0);
        @(negedge clk);
        check_eq("to_err", 32'(bus.fetch_err), 32'd1);
        check_eq("to_req_low", 32'(bus.imem_req), 32'd0);
        check_eq("to_state", 32'(fsm_state), 32'd3);
        bus.imem_ack    = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;
        check_eq("to_sticky", 32'(bus.fetch_err), 32'd1);
        check_eq("to_req_stay", 32'(bus.imem_req), 32'd0);
        check_eq("to_valid_stay", 32'(bus.instr_valid), 32'd0);
        check_eq("to_addr_frozen", bus.imem_addr, model_pc);

        // Misaligned step at pc=0.
        apply_reset();
        fetch_one(0, 32'hFFFF_FF00, 0);
        fetch_one(0, 32'd6, 0);
        check_eq("mis_err", 32'(bus.fetch_err), 32'd1);
        check_eq("mis_req", 32'(bus.imem_req), 32'd0);
        check_eq("mis_valid", 32'(bus.instr_valid), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("mis_req_stay", 32'(bus.imem_req), 32'd0);
        check_eq("mis_pc", bus.imem_addr, 32'd6);

        // Reset pulse mid-REQ, with a late ack around the release.
        apply_reset();
        fetch_one(0, 32'd8, 0);
        @(negedge clk);
        check_eq("mid_req", 32'(bus.imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(bus.imem_req), 32'd0);
        check_eq("mid_rst_addr", bus.imem_addr, RST_PC);
        check_eq("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("mid_rst_instr", bus.instr, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = RST_PC;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check_eq("late_ack_valid", 32'(bus.instr_valid), 32'd0);
        fetch_one(0, 32'd4, 2);
        fetch_one(3, 32'd4, 0);

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
